md_unit: RTL and testbench

Parametrised multiply/divide unit that owns the HI/LO register pair of the pipelined MIPS core. It sits beside the ALU in the E stage. It accepts one operation per `start` pulse, holds `busy` for a configurable latency, then commits results to HI/LO. `busy` feeds the D-stage stall logic. `mthi`/`mtlo` writes land directly in HI/LO.

---
 rtl/md_unit.sv | 151 +++++++++++++++
 tb/tb_md_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit owning the HI/LO pair: fixed-latency ops commit to HI/LO after a busy window.
// Optional MDU_MADD_EN macro enables the madd/maddu/msub/msubu accumulate datapath (codes 4-7).
module md_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [1:0]       md_write,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
    localparam int unsigned PW         = 2 * WIDTH;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic             p_wr_q, p_wr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             op_signed, op_div, op_legal;
    logic [PW-1:0]    ext_a, ext_b, prod, acc, res;
    logic             a_neg, b_neg, div_by_zero;
    logic [WIDTH-1:0] a_mag, b_mag, den, q_mag, r_mag, quo, rem;
    logic             accept, commit;

    assign op_signed = ~md_op[0];
    assign op_div    = (md_op[2:1] == 2'b01);

    // Single shared multiplier: sign- or zero-extend both operands to 2*WIDTH.
    assign ext_a = {{WIDTH{op_signed & a[WIDTH-1]}}, a};
    assign ext_b = {{WIDTH{op_signed & b[WIDTH-1]}}, b};
    assign prod  = ext_a * ext_b;

    // Signed divide via magnitudes; the -2^(W-1) / -1 case falls out naturally.
    assign a_neg       = op_signed & a[WIDTH-1];
    assign b_neg       = op_signed & b[WIDTH-1];
    assign a_mag       = a_neg ? (-a) : a;
    assign b_mag       = b_neg ? (-b) : b;
    assign div_by_zero = (b == '0);
    assign den         = div_by_zero ? WIDTH'(1) : b_mag;
    assign q_mag       = a_mag / den;
    assign r_mag       = a_mag % den;
    assign quo         = (a_neg ^ b_neg) ? (-q_mag) : q_mag;
    assign rem         = a_neg ? (-r_mag) : r_mag;

`ifdef MDU_MADD_EN
    assign op_legal = 1'b1;
    assign acc      = md_op[1] ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`else
    assign op_legal = ~md_op[2];
    assign acc      = prod;
`endif

    always_comb begin
        if (op_div) begin
            res = {rem, quo};
        end else if (md_op[2]) begin
            res = acc;
        end else begin
            res = prod;
        end
    end

    assign commit = (state_q == S_RUN) && (cnt_q == CW'(1));
    assign accept = start && op_legal && ((state_q == S_IDLE) || commit);

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        p_wr_d  = p_wr_q;
        done_d  = 1'b0;

        if (commit) begin
            if (p_wr_q) begin
                hi_d = p_hi_q;
                lo_d = p_lo_q;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q - CW'(1);
        end

        if (accept) begin
            p_hi_d  = res[PW-1:WIDTH];
            p_lo_d  = res[WIDTH-1:0];
            p_wr_d  = !(op_div && div_by_zero);
            cnt_d   = op_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_d = S_RUN;
        end else if ((state_q == S_IDLE) && !start) begin
            if (md_write == 2'b01) begin
                hi_d = a;
            end else if (md_write == 2'b10) begin
                lo_d = a;
            end
        end

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            p_wr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            p_wr_q  <= p_wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver queues expected HI/LO and busy length, monitor checks on done.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [1:0]  md_write;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   busy_cnt   = 0;
    int   done_seen  = 0;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .md_write(md_write),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: counts busy cycles and compares HI/LO whenever done pulses.
    always @(negedge clk) begin
        if (!reset) begin
            busy_cnt = 0;
        end else if (done) begin
            done_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done hi=%h lo=%h", hi, lo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_hi", 64'(hi), 64'(e.hi));
                chk("result_lo", 64'(lo), 64'(e.lo));
                chk("busy_cycles", 64'(busy_cnt), 64'(e.cycles));
            end
            busy_cnt = busy ? 1 : 0;
        end else if (busy) begin
            busy_cnt++;
        end
    end

    task automatic expect_op(input logic [31:0] eh, input logic [31:0] el, input int cyc);
        exp_t e;
        e.hi = eh;
        e.lo = el;
        e.cycles = cyc;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [1:0] wr);
        start    = 1'b1;
        md_op    = op;
        a        = av;
        b        = bv;
        md_write = wr;
        @(negedge clk);
        start    = 1'b0;
        md_write = 2'b00;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout pending=%0d busy=%b", sb.size(), busy);
            sb.delete();
        end
    endtask

    initial begin
        int d0;
        reset = 1'b0; start = 1'b0; md_op = 3'd0; md_write = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // mult -1 * 2
        expect_op(32'hFFFFFFFF, 32'hFFFFFFFE, 5);
        issue(3'd0, 32'hFFFFFFFF, 32'd2, 2'b00);
        wait_idle();
        // divu 7/2
        expect_op(32'd1, 32'd3, 10);
        issue(3'd3, 32'd7, 32'd2, 2'b00);
        wait_idle();
        // div -7/2
        expect_op(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 2'b00);
        wait_idle();
        // div overflow
        expect_op(32'h0, 32'h80000000, 10);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 2'b00);
        wait_idle();
        // divide by zero leaves HI/LO unchanged
        expect_op(32'h0, 32'h80000000, 10);
        issue(3'd2, 32'd5, 32'd0, 2'b00);
        wait_idle();

        // mthi in IDLE
        md_write = 2'b01; a = 32'h1234;
        @(negedge clk);
        md_write = 2'b00;
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mthi_lo", 64'(lo), 64'h80000000);
        chk("mthi_done", 64'(done), 64'd0);

        // mtlo during RUN is ignored
        expect_op(32'd2, 32'd14, 10);
        issue(3'd3, 32'd100, 32'd7, 2'b00);
        md_write = 2'b10; a = 32'hDEAD;
        @(negedge clk);
        md_write = 2'b00;
        chk("run_write_lo", 64'(lo), 64'h80000000);
        wait_idle();

        // start+write together, then back-to-back multu at T0+5
        expect_op(32'd0, 32'd12, 5);
        issue(3'd1, 32'd3, 32'd4, 2'b01);
        chk("start_wins_hi", 64'(hi), 64'd2);
        repeat (4) @(negedge clk);
        expect_op(32'd0, 32'd30, 5);
        issue(3'd1, 32'd5, 32'd6, 2'b00);
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_first_lo", 64'(lo), 64'd12);
        wait_idle();

        // reset in the third cycle of a divide
        expect_op(32'd1, 32'd4, 10);
        issue(3'd3, 32'd9, 32'd2, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_hi", 64'(hi), 64'd0);
        chk("midreset_lo", 64'(lo), 64'd0);
        sb.delete();
        d0 = done_seen;
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("midreset_no_done", 64'(done_seen - d0), 64'd0);
        chk("midreset_idle", 64'(busy), 64'd0);

        md_write = 2'b10; a = 32'd10;
        @(negedge clk);
        md_write = 2'b00;
`ifdef MDU_MADD_EN
        expect_op(32'd0, 32'd22, 5);
        issue(3'd5, 32'd3, 32'd4, 2'b00);
        wait_idle();
        expect_op(32'hFFFFFFFF, 32'hFFFFFFF8, 5);
        issue(3'd6, 32'd1, 32'd30, 2'b00);
        wait_idle();
`else
        issue(3'd4, 32'd3, 32'd4, 2'b00);
        chk("illegal_busy0", 64'(busy), 64'd0);
        repeat (6) @(negedge clk);
        chk("illegal_busy1", 64'(busy), 64'd0);
        chk("illegal_hi", 64'(hi), 64'd0);
        chk("illegal_lo", 64'(lo), 64'd10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
